byte_serial_add_seq: RTL and testbench
======================================

# byte_serial_add_seq

Byte-serial wide-operand adder controller. Accepts two `8*NBYTES`-bit operands and a carry-in through a valid/ready handshake. Drives the team's 8-bit carry-in adder datapath one byte per cycle, least-significant byte first, and registers the carry between bytes. Consumes each byte's sum and carry-out and presents the assembled result with carry, signed-overflow and zero flags on an output valid/ready handshake. Sits directly downstream of operand sources and wraps the 8-bit adder so wide additions reuse one byte-wide adder.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range ≥ 1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand set presented.
- `in_ready` out 1: block can accept operands.
- `in_a` in `8*NBYTES`: operand A.
- `in_b` in `8*NBYTES`: operand B.
- `in_cin` in 1: carry into byte 0.
- `out_valid` out 1: result held on outputs.
- `out_ready` in 1: consumer takes result.
- `out_sum` out `8*NBYTES`: A+B+cin, modulo 2^(8*NBYTES).
- `out_carry` out 1: carry out of the top byte.
- `out_ovf` out 1: two's-complement overflow.
- `out_zero` out 1: `out_sum == 0`.

## Operation
- **States:**
  - IDLE → RUN on `in_valid && in_ready`.
  - RUN → DONE after byte `NBYTES-1` is processed.
  - DONE → IDLE on `out_valid && out_ready`.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). Both decode state only; no combinational path from inputs.
- **On acceptance:**
  - Latch `in_a`, `in_b` into shift/operand registers and `in_cin` into the carry register.
  - Clear the byte counter and the sum register.
  - Input changes after acceptance are ignored.
- **RUN cycle k (k = 0..NBYTES-1):**
  - Adder inputs are byte k of A, byte k of B, and the carry register.
  - Register the adder's sum into byte k of the sum register.
  - Register the adder's carry-out into the carry register.
  - Byte counter increments; it is `max(1,$clog2(NBYTES))` bits wide and is not required to wrap.
- **In the final RUN cycle:**
  - Also register the carry into the MSB of byte `NBYTES-1` (adder bit-7 carry = `a7^b7^s7`).
  - `out_ovf` = carry-into-MSB XOR carry-out.
  - `out_zero` is computed from the full sum register once in DONE; it may be combinational from the register.
- **DONE:**
  - All outputs are stable while `out_ready` is low.
  - No new operands are accepted until return to IDLE.
- **Reset, at any time including mid-RUN or DONE:**
  - State → IDLE, counter = 0.
  - `out_sum` = 0, `out_carry` = 0, `out_ovf` = 0, `out_zero` = 0.
  - `out_valid` = 0, `in_ready` = 1 from the first cycle after the reset edge.
  - Any in-flight operation is discarded and never emitted.
- `NBYTES = 1` degenerates to a single RUN cycle; no special casing is required beyond the counter-width rule.

## Timing
- Acceptance edge = E0. RUN occupies the cycles after E0 through E`NBYTES`. `out_valid` is high in the cycle after edge E`NBYTES`, i.e. latency `NBYTES+1` cycles from acceptance to `out_valid`.
- With `out_ready` held high: `out_valid` lasts 1 cycle, `in_ready` reasserts the next cycle. Peak throughput is one operation per `NBYTES+2` cycles.
- `in_ready` is low from the cycle after acceptance until the cycle after the output handshake.
- `out_*` data are registered; flags are valid in exactly the cycles `out_valid` is high.

## Structure
- **Package `add_seq_pkg`:**
  - `BYTE_W = 8`.
  - State enum `add_seq_state_t` {IDLE, RUN, DONE}.
  - Helper function for counter width.
- **Sub-module:** one instance of the team's 8-bit adder (`a`, `b`, `carry_in` → `sum`, `carry_out`) as the byte datapath. The controller owns all registers; the adder stays purely combinational.

## Test plan
- **Carry ripple, NBYTES=4:** A=0xFFFFFFFF, B=0x00000001, cin=0 → `out_sum`=0x00000000, carry=1, zero=1, ovf=0. `out_valid` rises exactly 5 cycles after acceptance.
- **Signed overflow:** A=0x7FFFFFFF, B=0x00000001, cin=0 → sum=0x80000000, ovf=1, carry=0, zero=0. Also A=0x80000000, B=0x80000000 → sum=0, carry=1, ovf=1, zero=1.
- **Carry-in across bytes:** A=0x000000FF, B=0, cin=1 → sum=0x00000100. During RUN, drive different `in_a`/`in_b`/`in_cin` values → result unchanged.
- **Backpressure:** hold `out_ready`=0 for 3 cycles in DONE.
  - Outputs stay bit-stable and `in_ready`=0 throughout.
  - On handshake, `in_ready`=1 the next cycle.
  - A second operand set is accepted and produces the correct result.
- **Reset mid-operation:** assert `rst` in the 2nd RUN cycle → next cycle state is IDLE, `in_ready`=1, `out_valid`=0, all `out_*`=0. No result is ever emitted for the aborted operation.
- **Randomised reference check, NBYTES=1 and NBYTES=4:** ≥1000 random operands with random `in_valid`/`out_ready` gaps. Compare against a reference model of `{carry,sum} = A+B+cin`, `ovf`, and `zero`.

Source files
------------

// File: rtl/byte_serial_add_seq_pkg.sv
// Shared constants and types for the byte-serial wide adder controller.
package add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_seq_state_t;

  // Byte counter width: max(1, clog2(nbytes)).
  function automatic int cnt_width(input int nbytes);
    return (nbytes <= 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/byte_serial_add_seq_if.sv
// Operand-in / result-out handshake bundle for byte_serial_add_seq.
interface byte_serial_add_seq_if
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
);
  localparam int W = BYTE_W * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_ovf;
  logic         out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
  );

endinterface

// File: rtl/byte_serial_add_seq_adder.sv
// Purely combinational 8-bit adder with carry-in; the shared byte datapath.
module byte_serial_add_seq_adder
  import add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              carry_in,
  output logic [BYTE_W-1:0] sum,
  output logic              carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, carry_in};

endmodule

// File: rtl/byte_serial_add_seq.sv
// Wide-operand adder that reuses one 8-bit adder, LS byte first, one byte per cycle.
module byte_serial_add_seq
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
)
(
  input  logic                 clk,
  input  logic                 rst,
  byte_serial_add_seq_if.slave bus
);

  localparam int              W    = BYTE_W * NBYTES;
  localparam int              CW   = cnt_width(NBYTES);
  localparam logic [CW-1:0]   LAST = CW'(NBYTES - 1);

  add_seq_state_t    state;
  logic [CW-1:0]     cnt;
  logic [W-1:0]      a_sh;
  logic [W-1:0]      b_sh;
  logic [W-1:0]      sum_r;
  logic              carry_r;
  logic              ovf_r;
  logic [BYTE_W-1:0] byte_sum;
  logic              byte_cout;
  logic              msb_cin;

  // Operand bytes are shifted down so the active byte is always at the bottom.
  byte_serial_add_seq_adder u_adder (
    .a         (a_sh[BYTE_W-1:0]),
    .b         (b_sh[BYTE_W-1:0]),
    .carry_in  (carry_r),
    .sum       (byte_sum),
    .carry_out (byte_cout)
  );

  // Carry into bit 7 of the current byte, recovered from the sum bit.
  assign msb_cin = a_sh[BYTE_W-1] ^ b_sh[BYTE_W-1] ^ byte_sum[BYTE_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state   <= RUN;
            cnt     <= '0;
            sum_r   <= '0;
            carry_r <= bus.in_cin;
            ovf_r   <= 1'b0;
          end
        end
        RUN: begin
          // Each new byte enters at the top; after NBYTES shifts byte k sits at position k.
          sum_r   <= (sum_r >> BYTE_W) | (W'(byte_sum) << (W - BYTE_W));
          carry_r <= byte_cout;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            ovf_r <= msb_cin ^ byte_cout;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      a_sh <= bus.in_a;
      b_sh <= bus.in_b;
    end else if (state == RUN) begin
      a_sh <= a_sh >> BYTE_W;
      b_sh <= b_sh >> BYTE_W;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = sum_r;
  assign bus.out_carry = carry_r;
  assign bus.out_ovf   = ovf_r;
  assign bus.out_zero  = (state == DONE) && (sum_r == '0);

endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Directed and reference-model checks of byte_serial_add_seq at NBYTES=4 and NBYTES=1.
module tb_byte_serial_add_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  byte_serial_add_seq_if #(.NBYTES(4)) bus4 ();
  byte_serial_add_seq_if #(.NBYTES(1)) bus1 ();

  byte_serial_add_seq #(.NBYTES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  byte_serial_add_seq #(.NBYTES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic start4(input logic [31:0] a, input logic [31:0] b, input logic cin);
    @(negedge clk);
    bus4.in_a = a; bus4.in_b = b; bus4.in_cin = cin; bus4.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
  endtask

  task automatic start1(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    bus1.in_a = a; bus1.in_b = b; bus1.in_cin = cin; bus1.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
  endtask

  // lat counts the acceptance edge as 1; returns at the first negedge with out_valid.
  task automatic wait4(output int lat);
    lat = 1;
    while (!bus4.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait1(output int lat);
    lat = 1;
    while (!bus1.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake4();
    bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus4.in_ready, bus4.out_valid, bus4.out_carry, bus4.out_ovf, bus4.out_zero} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctl4 got=%b exp=10000",
        {bus4.in_ready, bus4.out_valid, bus4.out_carry, bus4.out_ovf, bus4.out_zero});
    end
    total++;
    if (bus4.out_sum !== 32'h0) begin bad++; $display("FAIL reset_sum4 got=%h exp=0", bus4.out_sum); end
    total++;
    if ({bus1.in_ready, bus1.out_valid, bus1.out_carry, bus1.out_ovf, bus1.out_zero} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctl1 got=%b exp=10000",
        {bus1.in_ready, bus1.out_valid, bus1.out_carry, bus1.out_ovf, bus1.out_zero});
    end
    total++;
    if (bus1.out_sum !== 8'h0) begin bad++; $display("FAIL reset_sum1 got=%h exp=0", bus1.out_sum); end
    rst = 1'b0;
  endtask

  task automatic test_carry_ripple();
    int lat;
    start4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait4(lat);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL ripple_latency got=%0d exp=5", lat); end
    total++;
    if (bus4.out_sum !== 32'h0) begin bad++; $display("FAIL ripple_sum got=%h exp=00000000", bus4.out_sum); end
    total++;
    if ({bus4.out_carry, bus4.out_ovf, bus4.out_zero} !== 3'b101) begin
      bad++; $display("FAIL ripple_flags cov_z got=%b exp=101", {bus4.out_carry, bus4.out_ovf, bus4.out_zero});
    end
    handshake4();
    total++;
    if ({bus4.in_ready, bus4.out_valid} !== 2'b10) begin
      bad++; $display("FAIL ripple_after_hs rdy_vld got=%b exp=10", {bus4.in_ready, bus4.out_valid});
    end
  endtask

  task automatic test_overflow();
    int lat;
    start4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait4(lat);
    total++;
    if ({bus4.out_carry, bus4.out_ovf, bus4.out_zero, bus4.out_sum} !== {3'b010, 32'h8000_0000}) begin
      bad++; $display("FAIL ovf_pos cov_z_sum got=%b_%h exp=010_80000000",
        {bus4.out_carry, bus4.out_ovf, bus4.out_zero}, bus4.out_sum);
    end
    handshake4();
    start4(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait4(lat);
    total++;
    if ({bus4.out_carry, bus4.out_ovf, bus4.out_zero, bus4.out_sum} !== {3'b111, 32'h0}) begin
      bad++; $display("FAIL ovf_neg cov_z_sum got=%b_%h exp=111_00000000",
        {bus4.out_carry, bus4.out_ovf, bus4.out_zero}, bus4.out_sum);
    end
    handshake4();
  endtask

  task automatic test_cin_ignore();
    int lat;
    start4(32'h0000_00FF, 32'h0, 1'b1);
    bus4.in_a = 32'hDEAD_BEEF; bus4.in_b = 32'h1234_5678; bus4.in_cin = 1'b0;
    wait4(lat);
    total++;
    if ({bus4.out_carry, bus4.out_ovf, bus4.out_zero, bus4.out_sum} !== {3'b000, 32'h0000_0100}) begin
      bad++; $display("FAIL cin_ignore cov_z_sum got=%b_%h exp=000_00000100",
        {bus4.out_carry, bus4.out_ovf, bus4.out_zero}, bus4.out_sum);
    end
    handshake4();
  endtask

  task automatic test_backpressure();
    int lat;
    bus4.out_ready = 1'b0;
    start4(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait4(lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus4.out_valid, bus4.in_ready, bus4.out_carry, bus4.out_ovf, bus4.out_zero, bus4.out_sum}
          !== {5'b10000, 32'h2345_6789}) begin
        bad++; $display("FAIL bp_hold cyc=%0d vld_rdy_cov_z_sum got=%b_%h exp=10000_23456789", i,
          {bus4.out_valid, bus4.in_ready, bus4.out_carry, bus4.out_ovf, bus4.out_zero}, bus4.out_sum);
      end
    end
    handshake4();
    total++;
    if ({bus4.in_ready, bus4.out_valid} !== 2'b10) begin
      bad++; $display("FAIL bp_release rdy_vld got=%b exp=10", {bus4.in_ready, bus4.out_valid});
    end
    start4(32'h89AB_CDEF, 32'h7654_3210, 1'b1);
    wait4(lat);
    total++;
    if ({bus4.out_carry, bus4.out_ovf, bus4.out_zero, bus4.out_sum} !== {3'b101, 32'h0}) begin
      bad++; $display("FAIL bp_second cov_z_sum got=%b_%h exp=101_00000000",
        {bus4.out_carry, bus4.out_ovf, bus4.out_zero}, bus4.out_sum);
    end
    handshake4();
  endtask

  task automatic test_reset_mid();
    bit seen;
    start4(32'h0102_0304, 32'h0101_0101, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bus4.in_ready, bus4.out_valid, bus4.out_carry, bus4.out_ovf, bus4.out_zero} !== 5'b10000) begin
      bad++; $display("FAIL midrst_ctl got=%b exp=10000",
        {bus4.in_ready, bus4.out_valid, bus4.out_carry, bus4.out_ovf, bus4.out_zero});
    end
    total++;
    if (bus4.out_sum !== 32'h0) begin bad++; $display("FAIL midrst_sum got=%h exp=0", bus4.out_sum); end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus4.out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_emit got=%b exp=0", seen); end
  endtask

  task automatic test_random4();
    logic [31:0] a, b;
    logic        cin;
    logic [32:0] full;
    logic        eovf;
    int          lat;
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      full = {1'b0, a} + {1'b0, b} + 33'(cin);
      eovf = (a[31] == b[31]) && (full[31] != a[31]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start4(a, b, cin);
      wait4(lat);
      total++;
      if ({bus4.out_valid, bus4.out_carry, bus4.out_ovf, bus4.out_zero, bus4.out_sum}
          !== {1'b1, full[32], eovf, full[31:0] == 32'h0, full[31:0]}) begin
        bad++; $display("FAIL rand4 a=%h b=%h cin=%b got=%b_%h exp=1%b%b%b_%h", a, b, cin,
          {bus4.out_valid, bus4.out_carry, bus4.out_ovf, bus4.out_zero}, bus4.out_sum,
          full[32], eovf, full[31:0] == 32'h0, full[31:0]);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      handshake4();
      bus4.out_ready = 1'b0;
    end
    bus4.out_ready = 1'b1;
  endtask

  task automatic test_random1();
    logic [7:0] a, b;
    logic       cin;
    logic [8:0] full;
    logic       eovf;
    int         lat;
    bus1.out_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom_range(0, 1));
      full = {1'b0, a} + {1'b0, b} + 9'(cin);
      eovf = (a[7] == b[7]) && (full[7] != a[7]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start1(a, b, cin);
      wait1(lat);
      total++;
      if ({bus1.out_valid, bus1.out_carry, bus1.out_ovf, bus1.out_zero, bus1.out_sum}
          !== {1'b1, full[8], eovf, full[7:0] == 8'h0, full[7:0]}) begin
        bad++; $display("FAIL rand1 a=%h b=%h cin=%b lat=%0d got=%b_%h exp=1%b%b%b_%h", a, b, cin, lat,
          {bus1.out_valid, bus1.out_carry, bus1.out_ovf, bus1.out_zero}, bus1.out_sum,
          full[8], eovf, full[7:0] == 8'h0, full[7:0]);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus1.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 1'b0; bus4.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0; bus1.out_ready = 1'b1;
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_cin_ignore();
    test_backpressure();
    test_reset_mid();
    test_random4();
    test_random1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
